// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends 0x80, zero fill and the 64-bit big-endian bit length.
// Define SHA256_PADDER_LEN_ERR_EN to add the sticky len_err flag, which is set when the bit counter overflows.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_keep,
  input  logic         in_last,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_first,
  output logic         block_last,
  output logic         len_err
);

  typedef enum logic [1:0] {FILL, OUT_DATA, OUT_PAD, OUT_LEN} state_t;

  state_t           state;
  logic [0:63][7:0] buf_q;
  logic [6:0]       n;
  logic [LEN_W-1:0] bit_cnt;
  logic             first_q;
  logic             last_q;
  logic             pad_pending;

  logic             in_fire;
  logic             blk_fire;
  logic [6:0]       m;
  logic [LEN_W-1:0] cnt_inc;
  logic [LEN_W-1:0] cnt_fin;
  logic [63:0]      len_fin;
  logic [63:0]      len_cur;
  logic [0:63][7:0] pad_blk;
  logic [0:63][7:0] len_blk;

  assign in_ready    = (state == FILL) && !reset;
  assign block_valid = (state != FILL);
  assign block_out   = buf_q;
  assign block_first = first_q;
  assign block_last  = last_q;
  assign in_fire     = in_valid && in_ready;
  assign blk_fire    = block_valid && block_ready;

  assign m       = in_keep ? n + 7'd1 : n;
  assign cnt_inc = bit_cnt + LEN_W'(8);
  assign cnt_fin = in_keep ? cnt_inc : bit_cnt;
  assign len_fin = 64'(cnt_fin);
  assign len_cur = 64'(bit_cnt);

  // Final data block: bytes past n are already zero, so only the marker and length need placing.
  // NOTE: every variable written here gets a full default first, so no latch can be inferred.
  always_comb begin
    pad_blk = buf_q;
    if (in_keep) pad_blk[n[5:0]] = in_data;
    if (!m[6]) pad_blk[m[5:0]] = 8'h80;
    if (m <= 7'd55) pad_blk[56:63] = len_fin;
  end

  always_comb begin
    len_blk        = '0;
    len_blk[0]     = pad_pending ? 8'h80 : 8'h00;
    len_blk[56:63] = len_cur;
  end

  // NOTE: the block buffer is reset, not just the control state, because block_out must read 0 after reset.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FILL;
      buf_q       <= '0;
      n           <= '0;
      bit_cnt     <= '0;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
      pad_pending <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            if (in_last) begin
              buf_q       <= pad_blk;
              bit_cnt     <= cnt_fin;
              last_q      <= (m <= 7'd55);
              pad_pending <= m[6];
              state       <= OUT_PAD;
            end else if (in_keep) begin
              buf_q[n[5:0]] <= in_data;
              n             <= n + 7'd1;
              bit_cnt       <= cnt_inc;
              if (n == 7'd63) begin
                last_q <= 1'b0;
                state  <= OUT_DATA;
              end
            end
          end
        end
        OUT_DATA: begin
          if (blk_fire) begin
            buf_q   <= '0;
            n       <= '0;
            first_q <= 1'b0;
            state   <= FILL;
          end
        end
        OUT_PAD: begin
          if (blk_fire) begin
            if (last_q) begin
              buf_q       <= '0;
              n           <= '0;
              bit_cnt     <= '0;
              first_q     <= 1'b1;
              last_q      <= 1'b0;
              pad_pending <= 1'b0;
              state       <= FILL;
            end else begin
              buf_q   <= len_blk;
              first_q <= 1'b0;
              last_q  <= 1'b1;
              state   <= OUT_LEN;
            end
          end
        end
        OUT_LEN: begin
          if (blk_fire) begin
            buf_q       <= '0;
            n           <= '0;
            bit_cnt     <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            pad_pending <= 1'b0;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef SHA256_PADDER_LEN_ERR_EN
  logic len_err_q;

  // The counter only ever holds multiples of 8, so it wraps exactly when the bits above bit 2 are all ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_err_q <= 1'b0;
    end else if (in_fire && in_keep && (&bit_cnt[LEN_W-1:3])) begin
      len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: a reference padder fills a scoreboard, and a monitor compares each transferred block.
module tb_sha256_padder;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_keep;
  logic         in_last;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic         block_first;
  logic         block_last;
  logic         len_err;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;  // 0: always ready, 1: held low, 2: random

  sha256_padder #(.LEN_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_keep     (in_keep),
    .in_last     (in_last),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_first (block_first),
    .block_last  (block_last),
    .len_err     (len_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference padder: append 0x80, zero-fill to 56 mod 64, append the 64-bit bit length, then split into blocks.
  task automatic model_push(input byte_q_t msg);
    byte_q_t     p;
    exp_t        e;
    logic [63:0] bitlen;
    int          nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = p[b*64+k];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_slot(input logic [7:0] d, input logic keep, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = keep;
    in_last  = last;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 2000) check("in_accept_timeout", 512'(n), 0);
    step();
    in_valid = 1'b0;
    in_keep  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg, input bit empty_term, input bit bubbles, input bit push_model);
    if (push_model) model_push(msg);
    for (int i = 0; i < msg.size(); i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) drive_slot(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      drive_slot(msg[i], 1'b1, !empty_term && (i == msg.size() - 1));
    end
    if (empty_term || msg.size() == 0) drive_slot(8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 2000) check("drain_timeout", 512'(sb.size()), 0);
    step();
  endtask

  initial begin
    block_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       block_ready = 1'b1;
        1:       block_ready = 1'b0;
        default: block_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every block transfer pops the oldest expected block.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && block_valid && block_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_block", 512'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check("block_out", block_out, e.blk);
          check("block_first", 512'(block_first), 512'(e.first));
          check("block_last", 512'(block_last), 512'(e.last));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t abc;
    byte_q_t msg;
    int      lens[10] = '{1, 55, 56, 63, 64, 65, 119, 120, 127, 128};

    abc = '{8'h61, 8'h62, 8'h63};
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_keep  = 1'b0;
    in_last  = 1'b0;
    repeat (3) step();
    check("rst_in_ready_low", 512'(in_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 512'(in_ready), 1);
    check("rst_block_valid", 512'(block_valid), 0);
    check("rst_block_out", block_out, 0);
    check("rst_block_first", 512'(block_first), 1);
    check("rst_block_last", 512'(block_last), 0);
    check("rst_len_err", 512'(len_err), 0);
    step();

    // "abc", empty message, 56 zero bytes, 64 0xFF bytes
    send_msg(abc, 1'b0, 1'b0, 1'b1);
    wait_drain();
    msg = {};
    send_msg(msg, 1'b1, 1'b0, 1'b1);
    wait_drain();
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'h00);
    send_msg(msg, 1'b0, 1'b0, 1'b1);
    wait_drain();
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'hFF);
    send_msg(msg, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Backpressure: block held for five cycles, then a single transfer.
    ready_mode = 1;
    step();
    send_msg(abc, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clock);
      check("stall_valid", 512'(block_valid), 1);
      check("stall_in_ready", 512'(in_ready), 0);
      check("stall_block_out", block_out, sb[0].blk);
    end
    ready_mode = 0;
    repeat (4) @(negedge clock);
    check("stall_single_xfer", 512'(sb.size()), 0);
    check("stall_valid_drop", 512'(block_valid), 0);
    step();

    // Reset while a block is waiting for the core.
    ready_mode = 1;
    step();
    send_msg(abc, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check("hs_rst_in_ready", 512'(in_ready), 0);
    reset = 1'b0;
    ready_mode = 0;
    @(negedge clock);
    check("hs_rst_valid", 512'(block_valid), 0);
    check("hs_rst_first", 512'(block_first), 1);
    check("hs_rst_block_out", block_out, 0);
    step();

    // Reset after 30 bytes of a message, then "abc".
    for (int i = 0; i < 30; i++) drive_slot(8'(i + 1), 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    send_msg(abc, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Boundary lengths with random backpressure, idle slots and keep=0 terminators.
    ready_mode = 2;
    for (int t = 0; t < 10; t++) begin
      msg = {};
      for (int i = 0; i < lens[t]; i++) msg.push_back(8'($urandom_range(0, 255)));
      send_msg(msg, (t % 3 == 1), 1'b1, 1'b1);
    end
    wait_drain();
    ready_mode = 0;
    step();
    check("final_len_err", 512'(len_err), 0);
    check("final_sb_empty", 512'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
